// File: rtl/fib_arb_pkg.sv
// Shared definitions for the Fibonacci-engine request arbiter.
package fib_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam int IDX_W       = 5;
  localparam int DATA_W      = 20;
  localparam int DEF_MAX_IDX = 30;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first set request at or above ptr, wrapping to 0.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               vld,
  output logic [PTR_W-1:0]   sel
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    // scan downward so the nearest requester after ptr wins
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = PTR_W'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    sel = sum[PTR_W-1:0];
    vld = |req;
  end

endmodule

// File: rtl/fib_req_arbiter.sv
// Shares one Fibonacci engine between NUM_REQ requesters with round-robin
// arbitration, index range check and a completion timeout.
module fib_req_arbiter
  import fib_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_IDX     = DEF_MAX_IDX,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     fib_start,
  output logic [IDX_W-1:0]         fib_i,
  input  logic                     fib_ready,
  input  logic                     fib_done_tick,
  input  logic [DATA_W-1:0]        fib_f
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [IDX_W-1:0] MAX_IDX_L = IDX_W'(MAX_IDX);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt;
  logic             pick_vld;
  logic [PTR_W-1:0] pick_sel;
  logic [IDX_W-1:0] pick_idx;
  logic             idx_ok;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req (req),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .sel (pick_sel)
  );

  assign idx_ok = (idx_q <= MAX_IDX_L);

  // Decoded purely from registered state so the pulses carry no input paths
  assign gnt        = (state == ST_ISSUE) ? (NUM_REQ'(1) << owner) : '0;
  assign resp_valid = (state == ST_RESP)  ? (NUM_REQ'(1) << owner) : '0;
  assign fib_start  = (state == ST_ISSUE) && idx_ok;

  always_comb begin
    state_nxt = state;
    pick_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_sel == PTR_W'(k)) pick_idx = req_idx[k*IDX_W +: IDX_W];
    end
    case (state)
      ST_IDLE:  if (fib_ready && pick_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = idx_ok ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (fib_done_tick || (cnt == CNT_LAST)) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      idx_q     <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      busy      <= 1'b0;
      fib_i     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_ISSUE) begin
            owner <= pick_sel;
            idx_q <= pick_idx;
            // fib_i only ever shows indices actually sent to the engine
            if (pick_idx <= MAX_IDX_L) fib_i <= pick_idx;
          end
        end
        ST_ISSUE: begin
          rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
          cnt    <= '0;
          if (!idx_ok) begin
            resp_err  <= 1'b1;
            resp_data <= '0;
          end
        end
        ST_WAIT: begin
          if (fib_done_tick) begin
            resp_data <= fib_f;
            resp_err  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_req_arbiter.sv
// Scoreboard bench for fib_req_arbiter with a behavioural Fibonacci engine.
module tb_fib_req_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] req_idx;
  logic [3:0]  gnt;
  logic [3:0]  resp_valid;
  logic [19:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        fib_start;
  logic [4:0]  fib_i;
  logic        fib_ready;
  logic        fib_done_tick;
  logic [19:0] fib_f;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_resp;
    int          who;
    bit          start;
    logic [4:0]  i;
    logic [19:0] data;
    bit          err;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  fib_req_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .MAX_IDX     (30),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_idx       (req_idx),
    .gnt           (gnt),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .busy          (busy),
    .fib_start     (fib_start),
    .fib_i         (fib_i),
    .fib_ready     (fib_ready),
    .fib_done_tick (fib_done_tick),
    .fib_f         (fib_f)
  );

  always #5 clk = ~clk;

  // Behavioural engine: completes 5 cycles after start unless hung
  logic        eng_busy;
  logic        eng_hang  = 1'b0;
  logic        eng_block = 1'b0;
  int          eng_cnt;
  logic [19:0] eng_res;

  function automatic logic [19:0] fib_calc(input logic [4:0] n);
    logic [19:0] a, b, t;
    a = 20'd0;
    b = 20'd1;
    for (int k = 0; k < 32; k++) begin
      if (k < int'(n)) begin
        t = a + b;
        a = b;
        b = t;
      end
    end
    return a;
  endfunction

  assign fib_ready = !eng_busy && !eng_block;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_busy      <= 1'b0;
      eng_cnt       <= 0;
      eng_res       <= '0;
      fib_done_tick <= 1'b0;
      fib_f         <= '0;
    end else begin
      fib_done_tick <= 1'b0;
      if (!eng_busy && fib_start) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 4;
        eng_res  <= fib_calc(fib_i);
      end else if (eng_busy && !eng_hang) begin
        if (eng_cnt == 0) begin
          fib_done_tick <= 1'b1;
          fib_f         <= eng_res;
          eng_busy      <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_g(input int who, input bit start, input logic [4:0] i);
    ev_t e;
    e = '{is_resp: 1'b0, who: who, start: start, i: i, data: 20'd0, err: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_r(input int who, input logic [19:0] d, input bit err);
    ev_t e;
    e = '{is_resp: 1'b1, who: who, start: 1'b0, i: 5'd0, data: d, err: err};
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid == 4'd0 && n < budget);
    if (resp_valid == 4'd0) chk("resp_wait_expired", 32'(resp_valid), 32'd1);
  endtask

  task automatic run_until_resps(input int want, input string name);
    int nr, cyc;
    nr  = 0;
    cyc = 0;
    while (nr < want && cyc < 400) begin
      @(negedge clk);
      cyc++;
      req = req & ~gnt;
      if (resp_valid != 4'd0) nr++;
    end
    chk(name, 32'(nr), 32'(want));
  endtask

  // Monitor: every presented grant/response is matched against the queue
  always @(negedge clk) begin
    if (reset) begin
      if (gnt != 4'd0) begin
        if (exp_q.size() == 0 || exp_q[0].is_resp) begin
          chk("unexpected_gnt", 32'(gnt), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("gnt_owner", 32'(gnt), 32'(1) << mon_e.who);
          chk("gnt_fib_start", 32'(fib_start), 32'(mon_e.start));
          if (mon_e.start) chk("gnt_fib_i", 32'(fib_i), 32'(mon_e.i));
        end
      end
      if (resp_valid != 4'd0) begin
        if (exp_q.size() == 0 || !exp_q[0].is_resp) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_owner", 32'(resp_valid), 32'(1) << mon_e.who);
          chk("resp_data", 32'(resp_data), 32'(mon_e.data));
          chk("resp_err", 32'(resp_err), 32'(mon_e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    reset   = 1'b0;
    req     = '0;
    req_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fib_start", 32'(fib_start), 32'd0);
    chk("rst_fib_i", 32'(fib_i), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Round-robin with all four requesters, including the largest legal index
    req_idx = {5'd30, 5'd20, 5'd1, 5'd0};
    push_g(0, 1, 5'd0);  push_r(0, 20'd0, 0);
    push_g(1, 1, 5'd1);  push_r(1, 20'd1, 0);
    push_g(2, 1, 5'd20); push_r(2, 20'd6765, 0);
    push_g(3, 1, 5'd30); push_r(3, 20'd832040, 0);
    req = 4'hF;
    run_until_resps(4, "rr_all_responses");
    @(negedge clk);

    // Single request; pointer has wrapped back to 0
    req_idx[4:0] = 5'd10;
    push_g(0, 1, 5'd10); push_r(0, 20'd55, 0);
    req = 4'b0001;
    @(negedge clk);
    chk("single_gnt_latency", 32'(gnt), 32'd1);
    chk("single_busy_high", 32'(busy), 32'd1);
    req = '0;
    wait_resp(50, n);
    @(negedge clk);
    chk("single_busy_drop", 32'(busy), 32'd0);

    // Out-of-range index
    req_idx[14:10] = 5'd31;
    push_g(2, 0, 5'd0); push_r(2, 20'd0, 1);
    req = 4'b0100;
    @(negedge clk);
    chk("range_gnt", 32'(gnt), 32'd4);
    req = '0;
    @(negedge clk);
    chk("range_resp_latency", 32'(resp_valid), 32'd4);
    @(negedge clk);
    chk("fib_i_holds_last_issued", 32'(fib_i), 32'd10);

    // Timeout: engine hangs, late completion must be ignored
    eng_hang      = 1'b1;
    req_idx[9:5]  = 5'd7;
    push_g(1, 1, 5'd7); push_r(1, 20'd0, 1);
    req = 4'b0010;
    @(negedge clk);
    chk("timeout_gnt", 32'(gnt), 32'd2);
    req = '0;
    wait_resp(200, n);
    chk("timeout_latency", 32'(n), 32'(TIMEOUT_CYC + 1));
    eng_hang = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid != 4'd0) seen++;
    end
    chk("late_done_ignored", 32'(seen), 32'd0);

    // Engine busy holds off arbitration
    eng_block       = 1'b1;
    req_idx[19:15]  = 5'd8;
    push_g(3, 1, 5'd8); push_r(3, 20'd21, 0);
    req = 4'b1000;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != 4'd0) seen++;
    end
    chk("blocked_no_gnt", 32'(seen), 32'd0);
    eng_block = 1'b0;
    @(negedge clk);
    chk("unblock_gnt", 32'(gnt), 32'd8);
    req = '0;
    wait_resp(50, n);
    @(negedge clk);

    // Reset during WAIT: response lost, pointer back to 0
    req_idx[14:10] = 5'd25;
    push_g(2, 1, 5'd25);
    req = 4'b0100;
    @(negedge clk);
    chk("rstwait_gnt", 32'(gnt), 32'd4);
    req = '0;
    @(negedge clk);
    chk("rstwait_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_resp_data", 32'(resp_data), 32'd0);
    chk("async_rst_fib_i", 32'(fib_i), 32'd0);
    chk("async_rst_outputs", 32'({gnt, resp_valid, resp_err, fib_start}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_idx[9:5]   = 5'd5;
    req_idx[19:15] = 5'd12;
    push_g(1, 1, 5'd5);  push_r(1, 20'd5, 0);
    push_g(3, 1, 5'd12); push_r(3, 20'd144, 0);
    req = 4'b1010;
    run_until_resps(2, "post_reset_responses");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
